// File: rtl/pll_lock_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// master drives lock/soft-reset requests; slave (the sequencer) returns reset, ready and strobe.
interface pll_lock_if #(
  parameter int unsigned PW = 3
);
  logic          locked;
  logic          soft_rst;
  logic          dp_rst;
  logic          ready;
  logic          digit_en;
  logic [PW-1:0] phase;
  logic [7:0]    lock_loss_cnt;

  modport master (
    output locked,
    output soft_rst,
    input  dp_rst,
    input  ready,
    input  digit_en,
    input  phase,
    input  lock_loss_cnt
  );

  modport slave (
    input  locked,
    input  soft_rst,
    output dp_rst,
    output ready,
    output digit_en,
    output phase,
    output lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Turns the asynchronous PLL lock flag into a clean datapath reset, ready flag and digit strobe.
// Optional lock-loss event counter is built when LOCK_LOSS_CNT_EN is defined.
module pll_lock_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned RATIO         = 8,
  parameter int unsigned PW            = $clog2(RATIO)
) (
  input logic        clk,
  input logic        rst,
  pll_lock_if.slave  bus
);

  typedef enum logic [1:0] {
    StWaitLock,
    StSettle,
    StResetHold,
    StRun
  } state_e;

  localparam int unsigned CntMax = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HoldLast   = CW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PhaseLast  = PW'(RATIO - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          phase_q, phase_d;

  // Only the synchronizer front stage ever looks at the raw lock flag.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StWaitLock: begin
        if (lock_s) state_d = StSettle;
      end
      StSettle: begin
        if (!lock_s)                 state_d = StWaitLock;
        else if (cnt_q == SettleLast) state_d = StResetHold;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      StResetHold: begin
        if (!lock_s)               state_d = StWaitLock;
        else if (cnt_q == HoldLast) state_d = StRun;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      StRun: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!lock_s)          state_d = StWaitLock;
        else if (bus.soft_rst) state_d = StResetHold;
      end
      default: state_d = StWaitLock;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Phase runs only while staying in RUN, so entry and exit both land on zero.
  always_comb begin
    phase_d = '0;
    if (state_q == StRun && state_d == StRun) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StWaitLock;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.dp_rst   = (state_q != StRun);
  assign bus.ready    = (state_q == StRun);
  assign bus.digit_en = (state_q == StRun) && (phase_q == PhaseLast);
  assign bus.phase    = phase_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == StRun && state_d == StWaitLock && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_cnt_q <= 8'd0;
    else     loss_cnt_q <= loss_cnt_d;
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized and directed bench for pll_lock_sequencer against a cycle-count reference model.
// Honours LOCK_LOSS_CNT_EN the same way as the design.
module tb_pll_lock_sequencer;

  localparam int SyncStages   = 2;
  localparam int SettleCycles = 16;
  localparam int HoldCycles   = 4;
  localparam int Ratio        = 8;
  localparam int Pw           = 3;
  localparam int RunStart     = SettleCycles + HoldCycles;
  localparam int LockLatency  = SyncStages + SettleCycles + HoldCycles + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pll_lock_if #(.PW(Pw)) bus ();

  pll_lock_sequencer #(
    .SYNC_STAGES  (SyncStages),
    .SETTLE_CYCLES(SettleCycles),
    .HOLD_CYCLES  (HoldCycles),
    .RATIO        (Ratio),
    .PW           (Pw)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec;
  int n_err;

  // Model: t = cycles since leaving WAIT_LOCK (-1 while waiting); RUN once t >= RunStart.
  int   t;
  int   loss;
  logic sq[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    t    = -1;
    loss = 0;
    sq.delete();
    for (int i = 0; i < SyncStages; i++) sq.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    logic ls;
    if (rst) begin
      model_reset();
      return;
    end
    ls = sq.pop_front();
    sq.push_back(bus.locked);
    if (!ls) begin
      if (t >= RunStart && loss < 255) loss++;
      t = -1;
    end else if (t < 0) begin
      t = 0;
    end else if (bus.soft_rst && t >= RunStart) begin
      t = SettleCycles;
    end else begin
      t++;
    end
  endfunction

  function automatic int exp_run();
    return (t >= RunStart) ? 1 : 0;
  endfunction

  function automatic int exp_phase();
    return (t >= RunStart) ? (t - RunStart) % Ratio : 0;
  endfunction

  function automatic int exp_loss();
`ifdef LOCK_LOSS_CNT_EN
    return loss;
`else
    return 0;
`endif
  endfunction

  task automatic compare_all();
    check_eq("dp_rst", int'(bus.dp_rst), 1 - exp_run());
    check_eq("ready", int'(bus.ready), exp_run());
    check_eq("phase", int'(bus.phase), exp_phase());
    check_eq("digit_en", int'(bus.digit_en), (exp_run() == 1 && exp_phase() == Ratio - 1) ? 1 : 0);
    check_eq("lock_loss_cnt", int'(bus.lock_loss_cnt), exp_loss());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic count_to_ready(input int limit, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (bus.ready !== 1'b1 && edges < limit);
  endtask

  int n;
  int first_de;
  int second_de;

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.locked   = 1'b0;
    bus.soft_rst = 1'b0;
    model_reset();

    // Power-up
    repeat (5) step();
    rst = 1'b0;
    repeat (3) step();

    // Clean lock
    bus.locked = 1'b1;
    count_to_ready(60, n);
    check_eq("lock_latency", n, LockLatency);
    first_de  = 0;
    second_de = 0;
    for (int r = 2; r <= 20; r++) begin
      step();
      if (bus.digit_en === 1'b1) begin
        if (first_de == 0) first_de = r;
        else if (second_de == 0) second_de = r;
      end
    end
    check_eq("first_digit_en", first_de, Ratio);
    check_eq("second_digit_en", second_de, 2 * Ratio);

    // soft_rst at phase 3
    n = 0;
    while (exp_phase() != 3 && n < 20) begin
      step();
      n++;
    end
    bus.soft_rst = 1'b1;
    step();
    bus.soft_rst = 1'b0;
    n = 0;
    while (bus.dp_rst === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check_eq("soft_hold_len", n, HoldCycles);
    check_eq("resume_phase", int'(bus.phase), 0);
    repeat (5) step();

    // soft_rst on the same edge the synchronized lock drops
    bus.locked = 1'b0;
    repeat (SyncStages) step();
    bus.soft_rst = 1'b1;
    step();
    bus.soft_rst = 1'b0;
    check_eq("simul_ready", int'(bus.ready), 0);
    repeat (4) step();

    // Settle glitch after 10 SETTLE cycles
    bus.locked = 1'b1;
    repeat (SyncStages + 10) step();
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    count_to_ready(60, n);
    check_eq("glitch_latency", n, LockLatency);
    repeat (3) step();

    // Three lock losses in RUN from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.locked = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.locked = 1'b1;
      count_to_ready(60, n);
      check_eq("relock_latency", n, LockLatency);
      repeat (k + 2) step();
      bus.locked = 1'b0;
      n = 0;
      do begin
        step();
        n++;
      end while (bus.dp_rst !== 1'b1 && n < 10);
      check_eq("loss_react", n, SyncStages + 1);
      repeat (2) step();
    end
`ifdef LOCK_LOSS_CNT_EN
    check_eq("loss_total", int'(bus.lock_loss_cnt), 3);
`else
    check_eq("loss_total", int'(bus.lock_loss_cnt), 0);
`endif

    // Async rst between edges, mid-RESET_HOLD then mid-RUN
    bus.locked = 1'b1;
    repeat (SyncStages + SettleCycles + 2) step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) step();
    rst = 1'b0;
    count_to_ready(60, n);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    rst = 1'b0;

    // Random lock segments with sporadic soft resets
    for (int seg = 0; seg < 80; seg++) begin
      bus.locked = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 50)) begin
        bus.soft_rst = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    bus.soft_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sits directly downstream of the PLL wrapper, clocked by its fast output clock (6.4 MHz, 8x the 0.8 MHz digit clock).
- Consumes the PLL `locked` flag and produces three things for the online-arithmetic datapath:
  - a clean synchronous datapath reset;
  - a ready flag;
  - a digit-rate clock-enable strobe with a phase counter.
- This lets downstream logic run single-clock, using the strobe instead of the slow PLL output.

Parameters:
- SYNC_STAGES, 2, number of flops in the `locked` synchronizer (minimum 2).
- SETTLE_CYCLES, 16, consecutive synchronized-locked cycles required before leaving SETTLE (minimum 1).
- HOLD_CYCLES, 4, cycles `dp_rst` is held after settle, before RUN (minimum 1).
- RATIO, 8, fast-clock cycles per digit slot (minimum 2).
- PW, $clog2(RATIO), width of `phase`.

Ports:
- clk  input  1  fast PLL output clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- locked  input  1  PLL lock flag; treated as asynchronous.
- soft_rst  input  1  synchronous request to re-run the HOLD sequence.
- dp_rst  output  1  datapath reset, synchronous to clk, active-high.
- ready  output  1  high only in RUN.
- digit_en  output  1  one-cycle strobe per digit slot.
- phase  output  PW  position within the digit slot, 0..RATIO-1.
- lock_loss_cnt  output  8  count of lock-loss events (see Optional Feature).

Behaviour:
- Reset: asynchronous and active-high. While `rst` is high:
  - all synchronizer flops are 0 and state is WAIT_LOCK;
  - `dp_rst`=1, `ready`=0, `digit_en`=0, `phase`=0, `lock_loss_cnt`=0.
- Synchronizer:
  - `locked` passes through SYNC_STAGES flops to give `lock_s`.
  - No logic other than the synchronizer reads raw `locked`.
- Outputs:
  - `dp_rst` and `ready` are Moore decodes of the registered state.
  - `dp_rst`=1 in every state except RUN; `ready`=1 in RUN only.
- State machine. An internal counter `cnt` is cleared on every state entry. Transitions:
  - WAIT_LOCK: `lock_s`=1 -> SETTLE.
  - SETTLE: `lock_s`=0 -> WAIT_LOCK. When `cnt`==SETTLE_CYCLES-1 -> RESET_HOLD. Otherwise `cnt`++.
  - RESET_HOLD: `lock_s`=0 -> WAIT_LOCK. When `cnt`==HOLD_CYCLES-1 -> RUN. Otherwise `cnt`++.
  - RUN: `lock_s`=0 -> WAIT_LOCK. Else `soft_rst`=1 -> RESET_HOLD. Else stay.
- Latency:
  - Let edge 1 be the first clk edge that samples `locked`=1.
  - `ready` rises and `dp_rst` falls immediately after edge SYNC_STAGES+SETTLE_CYCLES+HOLD_CYCLES+1.
  - With defaults that is edge 23.
- Phase counter:
  - `phase` is 0 in all non-RUN states and is 0 on the first RUN cycle.
  - In RUN it increments every cycle and wraps from RATIO-1 to 0.
  - `digit_en` = (state==RUN) and (`phase`==RATIO-1), so the first strobe falls in the RATIO-th RUN cycle.
- Boundary conditions:
  - Lock dropping for even one synchronized cycle in SETTLE restarts the full settle count.
  - `soft_rst` in non-RUN states is ignored.
  - `soft_rst` and lock loss on the same edge: lock loss wins, next state is WAIT_LOCK.
  - Leaving RUN forces `phase`=0 and `digit_en`=0 on the next cycle; `digit_en` never asserts outside RUN.
  - `rst` asserted mid-sequence returns asynchronously to the full reset state.

Optional Feature:
- Macro: `LOCK_LOSS_CNT_EN`.
- Defined:
  - `lock_loss_cnt` increments by 1 on each RUN -> WAIT_LOCK transition.
  - It saturates at 255 and is cleared only by `rst`.
  - Losses during SETTLE or RESET_HOLD are not counted.
- Not defined: no counter is built and `lock_loss_cnt` is tied to 8'd0. The port is always present.

Test Plan:
- Power-up: `rst`=1 for 5 cycles, `locked`=0 -> `dp_rst`=1, `ready`=0, `phase`=0, `digit_en`=0 throughout.
- Clean lock, defaults: raise `locked` and hold -> `ready` rises after edge 23. `phase` then steps 0..7 and wraps. `digit_en` pulses exactly every 8th cycle, first in RUN cycle 8.
- Settle glitch: drop `locked` for 1 cycle after 10 SETTLE cycles -> state returns to WAIT_LOCK. `ready` rises a full 23 edges after `locked` re-rises.
- soft_rst in RUN at `phase`=3 -> `dp_rst`=1 and `ready`=0 for exactly 4 cycles, `phase` goes to 0, then RUN resumes with `phase`=0. Simultaneous `soft_rst` and `locked` drop -> WAIT_LOCK.
- Lock loss in RUN, repeated 3 times with `LOCK_LOSS_CNT_EN` defined -> `lock_loss_cnt`=3, `dp_rst` reasserted within SYNC_STAGES+1 cycles of each drop. With the macro undefined, `lock_loss_cnt` stays 0.
- Async `rst` pulse mid-RESET_HOLD, between clock edges -> outputs take their reset values immediately, without waiting for a clk edge.
